bit_deserializer_module: RTL and testbench
==========================================

BIT_DESERIALIZER_MODULE -- requirements
Module: bit_deserializer_module

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of bits per assembled word (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning the first accepted bit lands in word_out[WIDTH-1]; 0 means it lands in word_out[0].
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port bit_in, input, 1 bit: serial data bit, driven by the upstream shift_left_module out.
REQ-006 SHALL have port bit_valid, input, 1 bit: bit_in is accepted on any edge where this is high.
REQ-007 SHALL have port flush, input, 1 bit: discards the partial word.
REQ-008 SHALL have port word_out, output, WIDTH bits: the assembled word, stable while word_valid is high.
REQ-009 SHALL have port word_valid, output, 1 bit: word_out holds an unconsumed word.
REQ-010 SHALL have port word_ready, input, 1 bit: the consumer takes the word on an edge where word_valid and word_ready are both high.
REQ-011 SHALL have port bit_count, output, $clog2(WIDTH+1) bits: the number of bits in the partial word.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag for a dropped word.

Function
REQ-013 SHALL shift the accepted bit into the accumulator each valid edge:
- MSB_FIRST=1: shift left, new bit at [0].
- MSB_FIRST=0: shift right, new bit at [WIDTH-1].
REQ-014 SHALL increment bit_count per accepted bit; on the WIDTH-th bit, bit_count SHALL return to 0 on that edge (wrap, no WIDTH value ever visible).
REQ-015 SHALL, on the edge accepting the WIDTH-th bit, copy the completed accumulator (including that bit) to the output register.
- Latency: word_valid is high the cycle after the last bit.
REQ-016 SHALL implement an output FSM with two states:
- S_EMPTY: word_valid=0.
- S_FULL: word_valid=1.
- S_EMPTY->S_FULL on word completion.
- S_FULL->S_EMPTY on handshake without a simultaneous completion.
- S_FULL stays S_FULL on handshake with a simultaneous completion, loading the new word.
REQ-017 SHALL, when a word completes in S_FULL without a handshake on that edge:
- drop the new word;
- keep word_out unchanged;
- set overflow=1;
- still clear bit_count to 0.
REQ-018 SHALL keep overflow set until rst; no other event clears it.
REQ-019 SHALL, on flush, clear the accumulator and bit_count to 0 without affecting the output register, word_valid or overflow.
REQ-020 SHALL give flush priority over a same-edge bit_valid; that bit is discarded and does not complete a word.
REQ-021 SHALL accept bits continuously at one per cycle with no bubble between words.
REQ-022 SHALL hold word_out constant while word_valid=1 and no handshake occurs.

Reset
REQ-023 SHALL, while rst=1 at an edge, set the accumulator, word_out and bit_count to 0, word_valid and overflow to 0, and the FSM to S_EMPTY.
REQ-024 SHALL let rst override bit_valid, flush and word_ready on the same edge, discarding a partial or held word mid-operation.
REQ-025 SHALL accept a bit on the first edge after rst deasserts.

Structure
REQ-026 SHALL take the FSM state enum (S_EMPTY, S_FULL) and the default WIDTH constant from a shared package bit_deser_pkg.
REQ-027 SHALL put the accumulator and bit counter in one sub-module bit_shift_acc, which emits a done pulse and the completed word; the FSM and flags stay in the top.

Verification
REQ-028 SHALL check MSB-first assembly: bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles with word_ready=1 -> word_out=8'hA5 and word_valid=1 exactly one cycle after the 8th bit, and bit_count=0.
REQ-029 SHALL check LSB-first assembly: with MSB_FIRST=0, the same bit sequence -> word_out=8'hA5 reversed, i.e. 8'hA5.
- The sequence is a palindrome, so also drive 1,0,0,0,0,0,0,0 -> 8'h01.
REQ-030 SHALL check overflow: word_ready=0, 16 valid bits forming 8'h0F then 8'hF0 -> word_out remains 8'h0F and overflow=1 after the 16th bit; asserting word_ready then gives word_valid=0 and overflow stays 1.
REQ-031 SHALL check completion and drain on the same edge: back-to-back words 8'h01, 8'h80 with word_ready asserted on the completion edge of 8'h80 -> word_out=8'h80, word_valid=1, overflow=0.
REQ-032 SHALL check flush: 3 bits 1,1,1 then flush together with bit_valid=1 -> bit_count=0; the next 8 bits 0x55 -> word_out=8'h55.
REQ-033 SHALL check reset mid-operation: rst after 5 bits with a held word present -> word_valid=0, bit_count=0, word_out=8'h00, overflow=0.

Source files
------------

// File: rtl/bit_deser_pkg.sv
// Shared definitions for the bit deserializer: output FSM states and default word width.
package bit_deser_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/bit_shift_acc.sv
// Serial-to-parallel accumulator with bit counter; pulses done_o combinationally on the
// edge that accepts the final bit, with word_o carrying the completed word on that edge.
module bit_shift_acc #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   parameter int CW        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_in_i,
   input  logic             bit_valid_i,
   input  logic             flush_i,
   output logic             done_o,
   output logic [WIDTH-1:0] word_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] acc_q, acc_d, shifted_s;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_s;

   // next accumulator/counter; flush wins over a same-edge bit
   always_comb begin
      if (MSB_FIRST != 0) begin
         shifted_s = {acc_q[WIDTH-2:0], bit_in_i};
      end else begin
         shifted_s = {bit_in_i, acc_q[WIDTH-1:1]};
      end
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      done_s = 1'b0;
      if (flush_i) begin
         acc_d = {WIDTH{1'b0}};
         cnt_d = {CW{1'b0}};
      end else if (bit_valid_i) begin
         acc_d = shifted_s;
         if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d  = {CW{1'b0}};
            done_s = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // accumulator state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= {WIDTH{1'b0}};
         cnt_q <= {CW{1'b0}};
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign done_o  = done_s;
   assign word_o  = shifted_s;
   assign count_o = cnt_q;

endmodule

// File: rtl/bit_deserializer_module.sv
// Serial bit deserializer: assembles WIDTH-bit words and presents them through a
// valid/ready output register with a sticky overflow flag for dropped words.
module bit_deserializer_module
   import bit_deser_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MSB_FIRST = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       bit_in,
   input  logic                       bit_valid,
   input  logic                       flush,
   output logic [WIDTH-1:0]           word_out,
   output logic                       word_valid,
   input  logic                       word_ready,
   output logic [$clog2(WIDTH+1)-1:0] bit_count,
   output logic                       overflow
);

   localparam int CW = $clog2(WIDTH + 1);

   logic             done_s;
   logic [WIDTH-1:0] acc_word_s;
   state_e           state_q;
   logic [WIDTH-1:0] word_q;
   logic             valid_q;
   logic             ovf_q;

   bit_shift_acc #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST),
      .CW        (CW)
   ) u_acc (
      .clk         (clk),
      .rst         (rst),
      .bit_in_i    (bit_in),
      .bit_valid_i (bit_valid),
      .flush_i     (flush),
      .done_o      (done_s),
      .word_o      (acc_word_s),
      .count_o     (bit_count)
   );

   // output FSM; a word completing while the held one is not taken is dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         word_q  <= {WIDTH{1'b0}};
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (done_s) begin
                  word_q  <= acc_word_s;
                  valid_q <= 1'b1;
                  state_q <= S_FULL;
               end
            end
            S_FULL: begin
               if (word_ready) begin
                  if (done_s) begin
                     word_q <= acc_word_s;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= S_EMPTY;
                  end
               end else if (done_s) begin
                  ovf_q <= 1'b1;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= S_EMPTY;
            end
         endcase
      end
   end

   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_bit_deserializer_module.sv
// Directed self-checking bench for bit_deserializer_module (MSB-first and LSB-first instances).
module tb_bit_deserializer_module;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       flush = 1'b0;
   logic       word_ready = 1'b0;

   logic [7:0] m_word, l_word;
   logic       m_valid, l_valid;
   logic [3:0] m_cnt, l_cnt;
   logic       m_ovf, l_ovf;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   bit_deserializer_module #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
      .word_out(m_word), .word_valid(m_valid), .word_ready(word_ready),
      .bit_count(m_cnt), .overflow(m_ovf)
   );

   bit_deserializer_module #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
      .word_out(l_word), .word_valid(l_valid), .word_ready(word_ready),
      .bit_count(l_cnt), .overflow(l_ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic b);
      bit_in    = b;
      bit_valid = 1'b1;
      tick();
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) send(w[i]);
   endtask

   task automatic do_reset();
      rst = 1'b1; bit_valid = 1'b0; flush = 1'b0; word_ready = 1'b0; bit_in = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      chk_cnt++; if (m_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", m_valid); else pass_cnt++;
      chk_cnt++; if (m_cnt !== 4'd0) $display("FAIL rst_count got %0d exp 0", m_cnt); else pass_cnt++;
      chk_cnt++; if (m_word !== 8'h00) $display("FAIL rst_word got %h exp 00", m_word); else pass_cnt++;
      chk_cnt++; if (m_ovf !== 1'b0) $display("FAIL rst_ovf got %b exp 0", m_ovf); else pass_cnt++;
      chk_cnt++; if (l_valid !== 1'b0) $display("FAIL rst_lsb_valid got %b exp 0", l_valid); else pass_cnt++;
   endtask

   task automatic test_msb_first();
      logic [7:0] v;
      do_reset();
      word_ready = 1'b1;
      v = 8'hA5;
      for (int i = 7; i >= 1; i--) send(v[i]);
      chk_cnt++; if (m_cnt !== 4'd7) $display("FAIL msb_cnt7 got %0d exp 7", m_cnt); else pass_cnt++;
      chk_cnt++; if (m_valid !== 1'b0) $display("FAIL msb_early_valid got %b exp 0", m_valid); else pass_cnt++;
      send(v[0]);
      chk_cnt++; if (m_valid !== 1'b1) $display("FAIL msb_valid got %b exp 1", m_valid); else pass_cnt++;
      chk_cnt++; if (m_word !== 8'hA5) $display("FAIL msb_word got %h exp a5", m_word); else pass_cnt++;
      chk_cnt++; if (m_cnt !== 4'd0) $display("FAIL msb_cnt_wrap got %0d exp 0", m_cnt); else pass_cnt++;
      bit_valid = 1'b0;
      tick();
      chk_cnt++; if (m_valid !== 1'b0) $display("FAIL msb_drain got %b exp 0", m_valid); else pass_cnt++;
   endtask

   task automatic test_lsb_first();
      do_reset();
      word_ready = 1'b1;
      send_word(8'hA5);
      chk_cnt++; if (l_word !== 8'hA5) $display("FAIL lsb_word_a5 got %h exp a5", l_word); else pass_cnt++;
      chk_cnt++; if (l_valid !== 1'b1) $display("FAIL lsb_valid got %b exp 1", l_valid); else pass_cnt++;
      send_word(8'h80);
      bit_valid = 1'b0;
      chk_cnt++; if (l_word !== 8'h01) $display("FAIL lsb_word_01 got %h exp 01", l_word); else pass_cnt++;
      chk_cnt++; if (m_word !== 8'h80) $display("FAIL msb_word_80 got %h exp 80", m_word); else pass_cnt++;
   endtask

   task automatic test_overflow();
      do_reset();
      send_word(8'h0F);
      send_word(8'hF0);
      bit_valid = 1'b0;
      chk_cnt++; if (m_word !== 8'h0F) $display("FAIL ovf_word got %h exp 0f", m_word); else pass_cnt++;
      chk_cnt++; if (m_ovf !== 1'b1) $display("FAIL ovf_flag got %b exp 1", m_ovf); else pass_cnt++;
      chk_cnt++; if (m_cnt !== 4'd0) $display("FAIL ovf_cnt got %0d exp 0", m_cnt); else pass_cnt++;
      word_ready = 1'b1;
      tick();
      chk_cnt++; if (m_valid !== 1'b0) $display("FAIL ovf_drain got %b exp 0", m_valid); else pass_cnt++;
      chk_cnt++; if (m_ovf !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", m_ovf); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      do_reset();
      send_word(8'h01);
      v = 8'h80;
      for (int i = 7; i >= 1; i--) send(v[i]);
      chk_cnt++; if (m_word !== 8'h01) $display("FAIL b2b_hold got %h exp 01", m_word); else pass_cnt++;
      word_ready = 1'b1;
      send(v[0]);
      bit_valid = 1'b0;
      word_ready = 1'b0;
      chk_cnt++; if (m_word !== 8'h80) $display("FAIL b2b_word got %h exp 80", m_word); else pass_cnt++;
      chk_cnt++; if (m_valid !== 1'b1) $display("FAIL b2b_valid got %b exp 1", m_valid); else pass_cnt++;
      chk_cnt++; if (m_ovf !== 1'b0) $display("FAIL b2b_ovf got %b exp 0", m_ovf); else pass_cnt++;
   endtask

   task automatic test_flush();
      do_reset();
      word_ready = 1'b1;
      send(1'b1); send(1'b1); send(1'b1);
      chk_cnt++; if (m_cnt !== 4'd3) $display("FAIL flush_pre got %0d exp 3", m_cnt); else pass_cnt++;
      flush = 1'b1;
      send(1'b1);
      flush = 1'b0;
      chk_cnt++; if (m_cnt !== 4'd0) $display("FAIL flush_cnt got %0d exp 0", m_cnt); else pass_cnt++;
      send_word(8'h55);
      bit_valid = 1'b0;
      chk_cnt++; if (m_word !== 8'h55) $display("FAIL flush_word got %h exp 55", m_word); else pass_cnt++;
      chk_cnt++; if (m_valid !== 1'b1) $display("FAIL flush_valid got %b exp 1", m_valid); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_word(8'hA5);
      for (int i = 0; i < 5; i++) send(1'b1);
      chk_cnt++; if (m_cnt !== 4'd5) $display("FAIL mid_cnt got %0d exp 5", m_cnt); else pass_cnt++;
      chk_cnt++; if (m_valid !== 1'b1) $display("FAIL mid_held got %b exp 1", m_valid); else pass_cnt++;
      rst = 1'b1; word_ready = 1'b1; bit_valid = 1'b1;
      tick();
      rst = 1'b0; word_ready = 1'b0; bit_valid = 1'b0;
      chk_cnt++; if (m_valid !== 1'b0) $display("FAIL mid_valid got %b exp 0", m_valid); else pass_cnt++;
      chk_cnt++; if (m_cnt !== 4'd0) $display("FAIL mid_cnt0 got %0d exp 0", m_cnt); else pass_cnt++;
      chk_cnt++; if (m_word !== 8'h00) $display("FAIL mid_word got %h exp 00", m_word); else pass_cnt++;
      chk_cnt++; if (m_ovf !== 1'b0) $display("FAIL mid_ovf got %b exp 0", m_ovf); else pass_cnt++;
      send(1'b1);
      bit_valid = 1'b0;
      chk_cnt++; if (m_cnt !== 4'd1) $display("FAIL post_rst_bit got %0d exp 1", m_cnt); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_overflow();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
